seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised, time-multiplexed driver for a bank of common-anode/common-cathode seven-segment digits. Accepts a packed hex word, decodes each nibble to the full 0–F glyph set, and scans one digit at a time at a prescaled refresh rate. Updates are frame-synchronous, so a new value never appears partway through a scan. It sits between the datapath's display register interface and the board-level segment/digit pins. It is the multi-digit, clocked successor to the team's single-digit combinational decoder.

## Interface
- DIGITS, 4, number of digits scanned (1–8)
- CLK_DIV, 50000, clk cycles per digit slot (≥2)
- SEG_ACTIVE_LOW, 1, 1: seg/dp driven low = lit; 0: high = lit
- DIGIT_ACTIVE_LOW, 1, 1: selected digit_sel bit driven low; 0: driven high
- clk  in  1  single clock; all logic on rising edge
- rst  in  1  synchronous, active-high reset
- load  in  1  single-cycle request to capture value_in/dp_in
- value_in  in  4*DIGITS  nibble i (bits 4i+3:4i) = digit i; digit 0 is least significant
- dp_in  in  DIGITS  decimal point per digit
- lz_blank  in  1  1: suppress leading zeros
- enable  in  1  0: all outputs inactive; scanning continues
- seg  out  7  segments, bit0 = a … bit6 = g
- dp  out  1  decimal point of selected digit
- digit_sel  out  DIGITS  one-hot digit enable
- pending  out  1  a loaded value awaits the next frame boundary
- frame_done  out  1  one-cycle pulse when the scan wraps to digit 0

## Operation
- Prescaler `pcnt` counts 0..CLK_DIV-1 and wraps. `tick` is asserted when pcnt == CLK_DIV-1.
- Digit index `idx` advances on tick: 0→1→…→DIGITS-1→0. `wrap` = tick and idx == DIGITS-1.
- Capture: on load, value_in/dp_in are latched into the pending register and the pending flag is set. A later load before the frame boundary overwrites the pending register; the last load wins.
- Frame boundary: on wrap with the pending flag set, the pending register is copied into the display register and the flag is cleared.
- If load and wrap coincide, the transfer uses the old pending contents. The new load value goes into the pending register and the flag stays set, so it is applied at the following wrap.
- Decode (active-high, g..a): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71.
- Leading-zero suppression (lz_blank=1):
  - Digit i is blanked (pattern 00) if nibbles DIGITS-1 down to i are all zero.
  - Digit 0 is never blanked, so value 0 displays as "0".
  - dp is unaffected by blanking.
- Polarity: seg = SEG_ACTIVE_LOW ? ~pattern : pattern; dp likewise. digit_sel has only bit idx active, with DIGIT_ACTIVE_LOW polarity.
- enable=0: seg, dp and digit_sel are all driven inactive. pcnt, idx and load/transfer behave normally.

## Timing
- All outputs are registered. seg, dp and digit_sel reflect the idx and display register of the previous cycle (1-cycle latency).
- Reset values:
  - pcnt=0, idx=0, display=0, pending register=0, pending=0, frame_done=0.
  - seg, dp and digit_sel are inactive in the reset cycle.
- First cycle after reset release: digit 0 is selected showing "0" (if enable=1).
- Digit slot length is exactly CLK_DIV cycles; frame length is DIGITS*CLK_DIV cycles.
- frame_done is high for exactly the one cycle following the wrap edge.
- pending:
  - Rises in the cycle after load.
  - Falls in the cycle after the wrap that transfers the value.
  - A new value reaches the outputs 1 cycle after that wrap.
- Worst-case load-to-display latency: DIGITS*CLK_DIV+1 cycles.
- rst asserted mid-frame discards both the pending and display contents and restarts at idx 0 on the next cycle. A load in the same cycle as rst is ignored.

## Test plan
All scenarios use DIGITS=4, CLK_DIV=4, both polarities active-low.
- Reset / enable: rst for 2 cycles, then enable=1.
  - Required: seg=7'h40 (0x3F inverted), digit_sel=4'b1110, pending=0.
  - Slots of 4 cycles each; frame_done pulses every 16 cycles.
- Full hex decode: load value_in=16'hFEDC, lz_blank=0.
  - Required over the next frame after transfer: digit0 C (7'h46), digit1 d (7'h21), digit2 E (7'h06), digit3 F (7'h0E).
  - Sweep all 16 nibbles.
- Leading zeros: value 16'h0070, lz_blank=1.
  - Required: digits 3 and 2 seg=7'h7F (blank); digit1 7 (7'h78); digit0 0 (7'h40).
  - value 16'h0000 shows only digit0 "0".
- Tear-free update: load 16'h1234 mid-frame at idx=1.
  - Required: old value held until wrap; pending=1 until then; new value appears on digit0 one cycle after wrap.
  - load coincident with wrap is applied one frame later.
- Back-to-back loads: 16'h1111 then 16'h2222 within one frame.
  - Required: only 2222 is ever displayed.
- dp and blanking: dp_in=4'b1000 with value 16'h0005, lz_blank=1.
  - Required: digit3 seg=7'h7F and dp=0 (lit).
  - enable=0 forces seg=7'h7F, dp=1, digit_sel=4'b1111.
  - rst mid-frame returns to idx 0 showing "0".

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// Display bus between the datapath display register and the seven-segment
// scanner. The master side loads values and controls blanking/enable, the
// slave side (the scanner) drives the board-level segment and digit pins.
interface seven_seg_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  load;
  logic [4*DIGITS-1:0]   value_in;
  logic [DIGITS-1:0]     dp_in;
  logic                  lz_blank;
  logic                  enable;
  logic [6:0]            seg;
  logic                  dp;
  logic [DIGITS-1:0]     digit_sel;
  logic                  pending;
  logic                  frame_done;

  modport master (
    output load, value_in, dp_in, lz_blank, enable,
    input  seg, dp, digit_sel, pending, frame_done
  );

  modport slave (
    input  load, value_in, dp_in, lz_blank, enable,
    output seg, dp, digit_sel, pending, frame_done
  );
endinterface

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed seven-segment scanner. A prescaler divides clk into digit
// slots; one digit is lit per slot. Loaded values wait in a pending register
// and move to the display register only at the frame wrap, so a frame never
// mixes old and new digits. All pin outputs are registered.
module seven_seg_scanner #(
  parameter int DIGITS           = 4,
  parameter int CLK_DIV          = 50000,
  parameter bit SEG_ACTIVE_LOW   = 1'b1,
  parameter bit DIGIT_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  seven_seg_scanner_if.slave bus
);

  localparam int PCNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int VAL_W  = 4 * DIGITS;

  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

  // Inactive levels for each pin group, used in reset and when disabled.
  localparam logic [6:0]        SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = SEG_ACTIVE_LOW;
  localparam logic [DIGITS-1:0] SEL_OFF = {DIGITS{DIGIT_ACTIVE_LOW}};

  // Glyph table, active-high, bit0 = a ... bit6 = g.
  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] pat;
    pat = 7'h00;
    case (nib)
      4'h0: pat = 7'h3F;
      4'h1: pat = 7'h06;
      4'h2: pat = 7'h5B;
      4'h3: pat = 7'h4F;
      4'h4: pat = 7'h66;
      4'h5: pat = 7'h6D;
      4'h6: pat = 7'h7D;
      4'h7: pat = 7'h07;
      4'h8: pat = 7'h7F;
      4'h9: pat = 7'h6F;
      4'hA: pat = 7'h77;
      4'hB: pat = 7'h7C;
      4'hC: pat = 7'h39;
      4'hD: pat = 7'h5E;
      4'hE: pat = 7'h79;
      4'hF: pat = 7'h71;
    endcase
    return pat;
  endfunction

  // Map an active-high segment pattern onto the board polarity.
  function automatic logic [6:0] f_seg_pol(input logic [6:0] pat);
    return SEG_ACTIVE_LOW ? ~pat : pat;
  endfunction

  function automatic logic f_dp_pol(input logic lit);
    return SEG_ACTIVE_LOW ? ~lit : lit;
  endfunction

  function automatic logic [DIGITS-1:0] f_sel_pol(input logic [DIGITS-1:0] onehot);
    return DIGIT_ACTIVE_LOW ? ~onehot : onehot;
  endfunction

  // Scan control state
  logic [PCNT_W-1:0] r_pcnt;
  logic [IDX_W-1:0]  r_idx;
  logic              w_tick;
  logic              w_wrap;

  // Value storage: pending (next frame) and display (current frame)
  logic [VAL_W-1:0]  r_pend_val;
  logic [DIGITS-1:0] r_pend_dp;
  logic              r_pending;
  logic [VAL_W-1:0]  r_disp_val;
  logic [DIGITS-1:0] r_disp_dp;
  logic              r_frame_done;

  // Selected-digit decode (combinational, stage p0)
  logic [3:0]        w_nib_p0;
  logic              w_dp_bit_p0;
  logic              w_blank_p0;
  logic              w_zero_above_p0;
  logic [6:0]        w_pat_p0;
  logic [DIGITS-1:0] w_onehot_p0;

  // Registered pin drivers (stage p1)
  logic [6:0]        r_seg_p1;
  logic              r_dp_p1;
  logic [DIGITS-1:0] r_sel_p1;

  assign w_tick = (r_pcnt == PCNT_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  // Prescaler: one digit slot is exactly CLK_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pcnt <= '0;
    end else if (w_tick) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PCNT_W'(1);
    end
  end

  // Digit index advances once per slot and wraps after the last digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx <= '0;
    end else if (w_tick) begin
      if (r_idx == IDX_LAST) begin
        r_idx <= '0;
      end else begin
        r_idx <= r_idx + IDX_W'(1);
      end
    end
  end

  // Capture loads into the pending register; move pending to display at the
  // frame wrap. A load on the wrap edge transfers the old pending contents
  // and keeps the flag set for the newly captured value.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_val <= '0;
      r_pend_dp  <= '0;
      r_pending  <= 1'b0;
      r_disp_val <= '0;
      r_disp_dp  <= '0;
    end else begin
      if (w_wrap && r_pending) begin
        r_disp_val <= r_pend_val;
        r_disp_dp  <= r_pend_dp;
      end
      if (bus.load) begin
        r_pend_val <= bus.value_in;
        r_pend_dp  <= bus.dp_in;
        r_pending  <= 1'b1;
      end else if (w_wrap) begin
        r_pending  <= 1'b0;
      end
    end
  end

  // One-cycle pulse in the cycle following each frame wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= w_wrap;
    end
  end

  // ---- stage p0: pick the selected nibble and decide leading-zero blanking.
  // Walking from the most significant digit down, a digit is blank while
  // every nibble from the top down to it is zero; digit 0 always shows.
  always_comb begin
    w_nib_p0        = 4'h0;
    w_dp_bit_p0     = 1'b0;
    w_blank_p0      = 1'b0;
    w_zero_above_p0 = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      w_zero_above_p0 = w_zero_above_p0 && (r_disp_val[4*i +: 4] == 4'h0);
      if (r_idx == IDX_W'(i)) begin
        w_nib_p0    = r_disp_val[4*i +: 4];
        w_dp_bit_p0 = r_disp_dp[i];
        w_blank_p0  = bus.lz_blank && (i != 0) && w_zero_above_p0;
      end
    end
  end

  assign w_pat_p0    = w_blank_p0 ? 7'h00 : f_decode(w_nib_p0);
  assign w_onehot_p0 = DIGITS'(1) << r_idx;

  // ---- stage p1: register pin drivers; disabled or reset means all inactive.
  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      r_seg_p1 <= SEG_OFF;
      r_dp_p1  <= DP_OFF;
      r_sel_p1 <= SEL_OFF;
    end else begin
      r_seg_p1 <= f_seg_pol(w_pat_p0);
      r_dp_p1  <= f_dp_pol(w_dp_bit_p0);
      r_sel_p1 <= f_sel_pol(w_onehot_p0);
    end
  end

  assign bus.seg        = r_seg_p1;
  assign bus.dp         = r_dp_p1;
  assign bus.digit_sel  = r_sel_p1;
  assign bus.pending    = r_pending;
  assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner with DIGITS=4, CLK_DIV=4, active-low pins.
// A reference model tracks time since reset as a plain cycle count and derives
// the slot, frame boundary, transfer and glyph from that count.
module tb_seven_seg_scanner;
  localparam int DIGITS  = 4;
  localparam int CLK_DIV = 4;
  localparam int FRAME   = DIGITS * CLK_DIV;

  localparam logic [6:0] GLYPH [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seven_seg_scanner_if #(.DIGITS(DIGITS)) ifc();

  seven_seg_scanner #(
    .DIGITS(DIGITS), .CLK_DIV(CLK_DIV),
    .SEG_ACTIVE_LOW(1'b1), .DIGIT_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  // Observed vector: {seg, dp, digit_sel, pending, frame_done}
  logic [13:0] obs;
  assign obs = {ifc.seg, ifc.dp, ifc.digit_sel, ifc.pending, ifc.frame_done};

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          t;
  int unsigned m_disp, m_pv;
  logic [3:0]  m_dd, m_pdp;
  bit          m_pf;
  logic [13:0] exp_obs;

  // Advance one clock; update the model from the inputs seen at the edge,
  // then return on the falling edge where outputs are sampled.
  task automatic tick();
    int unsigned upper;
    int          slot;
    bit          boundary;
    logic [6:0]  pat;
    logic [6:0]  e_seg;
    logic        e_dp;
    logic [3:0]  e_sel;
    @(posedge clk);
    if (rst) begin
      t = 0; m_disp = 0; m_dd = 0; m_pv = 0; m_pdp = 0; m_pf = 0;
      exp_obs = {7'h7F, 1'b1, 4'hF, 1'b0, 1'b0};
    end else begin
      slot     = (t / CLK_DIV) % DIGITS;
      boundary = (t % FRAME) == FRAME - 1;
      upper    = m_disp >> (4 * slot);
      pat      = GLYPH[upper & 15];
      if (ifc.lz_blank && slot > 0 && upper == 0) pat = 7'h00;
      if (ifc.enable) begin
        e_seg = ~pat;
        e_dp  = ~m_dd[slot];
        e_sel = ~(4'b0001 << slot);
      end else begin
        e_seg = 7'h7F; e_dp = 1'b1; e_sel = 4'hF;
      end
      if (boundary && m_pf) begin
        m_disp = m_pv; m_dd = m_pdp; m_pf = 0;
      end
      if (ifc.load) begin
        m_pv = ifc.value_in; m_pdp = ifc.dp_in; m_pf = 1;
      end
      exp_obs = {e_seg, e_dp, e_sel, m_pf, boundary};
      t++;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    n_tests++;
    if (obs !== 14'({7'h7F, 1'b1, 4'hF, 1'b0, 1'b0})) begin
      n_fail++; $display("FAIL reset_state: got %h expected %h", obs, 14'({7'h7F, 1'b1, 4'hF, 2'b00}));
    end
    rst = 1'b0;
    ifc.enable = 1'b1;
    tick();
    n_tests++;
    if ({ifc.seg, ifc.digit_sel, ifc.pending} !== {7'h40, 4'b1110, 1'b0}) begin
      n_fail++; $display("FAIL first_after_reset: got seg=%h sel=%b pend=%b expected seg=40 sel=1110 pend=0",
                         ifc.seg, ifc.digit_sel, ifc.pending);
    end
  endtask

  task automatic test_frame_timing();
    int last_fd = -1;
    int fd_cnt  = 0;
    for (int k = 0; k < 48; k++) begin
      tick();
      n_tests++;
      if (obs !== exp_obs) begin
        n_fail++; $display("FAIL frame_model k=%0d: got %h expected %h", k, obs, exp_obs);
      end
      if (ifc.frame_done) begin
        fd_cnt++;
        if (last_fd >= 0) begin
          n_tests++;
          if (k - last_fd !== FRAME) begin
            n_fail++; $display("FAIL frame_period: got %0d expected %0d", k - last_fd, FRAME);
          end
        end
        last_fd = k;
      end
    end
    n_tests++;
    if (fd_cnt !== 3) begin
      n_fail++; $display("FAIL frame_done_count: got %0d expected 3", fd_cnt);
    end
  endtask

  task automatic test_hex_decode();
    logic [6:0] want [4] = '{7'h46, 7'h21, 7'h06, 7'h0E};
    int g = 0;
    ifc.lz_blank = 1'b0;
    ifc.value_in = 16'hFEDC; ifc.dp_in = 4'h0; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    while (ifc.pending && g < 40) begin
      g++; tick();
      n_tests++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL hex_wait: got %h expected %h", obs, exp_obs); end
    end
    n_tests++;
    if (ifc.pending) begin n_fail++; $display("FAIL hex_timeout: pending got 1 expected 0"); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      n_tests++;
      if ({ifc.seg, ifc.digit_sel} !== {want[k/4], ~(4'b0001 << (k/4))} || obs !== exp_obs) begin
        n_fail++; $display("FAIL hex_digit%0d: got seg=%h sel=%b expected seg=%h", k/4, ifc.seg, ifc.digit_sel, want[k/4]);
      end
    end
  endtask

  task automatic test_sweep();
    logic [15:0] vals [8] = '{16'h3210, 16'h7654, 16'hBA98, 16'hFEDC, 16'h0, 16'h0, 16'h0, 16'h0};
    for (int j = 4; j < 8; j++) vals[j] = 16'($urandom);
    for (int j = 0; j < 8; j++) begin
      int g = 0;
      ifc.lz_blank = (j >= 4) ? 1'($urandom) : 1'b0;
      ifc.value_in = vals[j]; ifc.dp_in = 4'($urandom); ifc.load = 1'b1;
      tick();
      ifc.load = 1'b0;
      while (ifc.pending && g < 40) begin g++; tick(); end
      n_tests++;
      if (ifc.pending) begin n_fail++; $display("FAIL sweep_timeout v=%h: pending got 1 expected 0", vals[j]); end
      for (int k = 0; k < FRAME; k++) begin
        tick();
        n_tests++;
        if (obs !== exp_obs) begin
          n_fail++; $display("FAIL sweep v=%h k=%0d: got %h expected %h", vals[j], k, obs, exp_obs);
        end
      end
    end
  endtask

  task automatic test_leading_zeros();
    logic [15:0] vals [2] = '{16'h0070, 16'h0000};
    logic [6:0]  want [2][4] = '{'{7'h40, 7'h78, 7'h7F, 7'h7F}, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
    ifc.lz_blank = 1'b1;
    for (int j = 0; j < 2; j++) begin
      int g = 0;
      ifc.value_in = vals[j]; ifc.dp_in = 4'h0; ifc.load = 1'b1;
      tick();
      ifc.load = 1'b0;
      while (ifc.pending && g < 40) begin g++; tick(); end
      for (int k = 0; k < FRAME; k++) begin
        tick();
        n_tests++;
        if (ifc.seg !== want[j][k/4] || obs !== exp_obs) begin
          n_fail++; $display("FAIL lz v=%h digit%0d: got seg=%h expected %h", vals[j], k/4, ifc.seg, want[j][k/4]);
        end
      end
    end
  endtask

  task automatic test_tear_free();
    int g = 0;
    int n;
    while ((t % FRAME) != 4 && g < 40) begin g++; tick(); end
    ifc.value_in = 16'h1234; ifc.dp_in = 4'h0; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    n = 0;
    while (ifc.pending && n < 40) begin
      n++; tick();
      n_tests++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL tear_hold: got %h expected %h", obs, exp_obs); end
    end
    n_tests++;
    if (n !== 11) begin n_fail++; $display("FAIL tear_pending_len: got %0d expected 11", n); end
    tick();
    n_tests++;
    if ({ifc.seg, ifc.digit_sel} !== {7'h19, 4'b1110}) begin
      n_fail++; $display("FAIL tear_new_digit0: got seg=%h sel=%b expected seg=19 sel=1110", ifc.seg, ifc.digit_sel);
    end
    // Load coinciding with wrap: old pending transfers, new one waits a frame.
    g = 0;
    while ((t % FRAME) != 8 && g < 40) begin g++; tick(); end
    ifc.value_in = 16'hABCD; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    g = 0;
    while ((t % FRAME) != FRAME - 1 && g < 40) begin g++; tick(); end
    ifc.value_in = 16'h5678; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    n_tests++;
    if (ifc.pending !== 1'b1 || ifc.frame_done !== 1'b1) begin
      n_fail++; $display("FAIL coincide_pending: got pend=%b fd=%b expected 1 1", ifc.pending, ifc.frame_done);
    end
    tick();
    n_tests++;
    if (ifc.seg !== 7'h21) begin n_fail++; $display("FAIL coincide_old: got seg=%h expected 21", ifc.seg); end
    n = 0;
    while (ifc.pending && n < 40) begin
      n++; tick();
      n_tests++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL coincide_hold: got %h expected %h", obs, exp_obs); end
    end
    n_tests++;
    if (n !== 15) begin n_fail++; $display("FAIL coincide_len: got %0d expected 15", n); end
    tick();
    n_tests++;
    if (ifc.seg !== 7'h00) begin n_fail++; $display("FAIL coincide_new: got seg=%h expected 00", ifc.seg); end
  endtask

  task automatic test_back_to_back();
    int g = 0;
    int seen1 = 0;
    int seen2 = 0;
    ifc.lz_blank = 1'b0;
    while ((t % FRAME) != 1 && g < 40) begin g++; tick(); end
    ifc.value_in = 16'h1111; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    tick();
    ifc.value_in = 16'h2222; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (ifc.seg === 7'h79) seen1++;
      if (ifc.seg === 7'h24) seen2++;
      n_tests++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL b2b_model: got %h expected %h", obs, exp_obs); end
    end
    n_tests++;
    if (seen1 !== 0 || seen2 < 8) begin
      n_fail++; $display("FAIL b2b_last_wins: got seen1111=%0d seen2222=%0d expected 0 and >=8", seen1, seen2);
    end
  endtask

  task automatic test_dp_blank_enable();
    int g = 0;
    ifc.lz_blank = 1'b1;
    ifc.value_in = 16'h0005; ifc.dp_in = 4'b1000; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    while (ifc.pending && g < 40) begin g++; tick(); end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      if (k / 4 == 3) begin
        n_tests++;
        if ({ifc.seg, ifc.dp} !== {7'h7F, 1'b0} || obs !== exp_obs) begin
          n_fail++; $display("FAIL dp_blank_digit3: got seg=%h dp=%b expected seg=7f dp=0", ifc.seg, ifc.dp);
        end
      end else if (k / 4 == 0) begin
        n_tests++;
        if ({ifc.seg, ifc.dp} !== {7'h12, 1'b1} || obs !== exp_obs) begin
          n_fail++; $display("FAIL dp_blank_digit0: got seg=%h dp=%b expected seg=12 dp=1", ifc.seg, ifc.dp);
        end
      end
    end
    ifc.enable = 1'b0;
    tick();
    ifc.value_in = 16'h4321; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if (obs[13:2] !== {7'h7F, 1'b1, 4'hF} || obs !== exp_obs) begin
        n_fail++; $display("FAIL disabled: got %h expected %h", obs, exp_obs);
      end
    end
    ifc.enable = 1'b1;
  endtask

  task automatic test_rst_mid();
    int g = 0;
    ifc.value_in = 16'h8888; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    while ((t % FRAME) != 6 && g < 40) begin g++; tick(); end
    rst = 1'b1;
    ifc.value_in = 16'h9999; ifc.load = 1'b1;
    tick();
    ifc.load = 1'b0;
    rst = 1'b0;
    n_tests++;
    if (obs !== 14'({7'h7F, 1'b1, 4'hF, 2'b00})) begin
      n_fail++; $display("FAIL rst_mid_inactive: got %h expected %h", obs, 14'({7'h7F, 1'b1, 4'hF, 2'b00}));
    end
    tick();
    n_tests++;
    if ({ifc.seg, ifc.digit_sel, ifc.pending} !== {7'h40, 4'b1110, 1'b0}) begin
      n_fail++; $display("FAIL rst_mid_restart: got seg=%h sel=%b pend=%b expected 40 1110 0",
                         ifc.seg, ifc.digit_sel, ifc.pending);
    end
    for (int k = 0; k < 20; k++) begin
      tick();
      n_tests++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL rst_mid_after: got %h expected %h", obs, exp_obs); end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      ifc.load     = ($urandom_range(0, 7) == 0);
      ifc.value_in = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      ifc.dp_in    = 4'($urandom);
      if ($urandom_range(0, 31) == 0) ifc.lz_blank = ~ifc.lz_blank;
      ifc.enable   = ($urandom_range(0, 15) != 0);
      rst          = ($urandom_range(0, 199) == 0);
      tick();
      n_tests++;
      if (obs !== exp_obs) begin n_fail++; $display("FAIL random k=%0d: got %h expected %h", k, obs, exp_obs); end
    end
    rst = 1'b0; ifc.load = 1'b0; ifc.enable = 1'b1;
  endtask

  initial begin
    rst = 1'b1;
    ifc.load = 1'b0; ifc.value_in = '0; ifc.dp_in = '0;
    ifc.lz_blank = 1'b0; ifc.enable = 1'b0;
    test_reset();
    test_frame_timing();
    test_hex_decode();
    test_sweep();
    test_leading_zeros();
    test_tear_free();
    test_back_to_back();
    test_dp_blank_enable();
    test_rst_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1, "watchdog");
  end
endmodule
